// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges pipeline writebacks with a one-entry
// buffered mul/div result, forcing a one-cycle pipeline stall if the buffer starves.
module rf_wb_arbiter #(
   parameter int STARVE_LIM = 4
) (
   input  logic        WBA_clk,
   input  logic        WBA_rst_n,
   input  logic        p_we,
   input  logic [4:0]  p_rdc,
   input  logic [31:0] p_rd,
   input  logic        md_valid,
   input  logic [4:0]  md_rdc,
   input  logic [31:0] md_rd,
   output logic        md_ready,
   output logic        pipe_stall,
   output logic        rf_w,
   output logic [4:0]  rf_rdc,
   output logic [31:0] rf_rd,
   output logic        buf_busy,
   output logic [4:0]  buf_rdc,
   output logic        err_drop,
   output logic [1:0]  fsm_state
);

   // MD handshake: a result transfers at the rising edge where md_valid and
   // md_ready are both 1; md_valid may be held or dropped freely otherwise.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } state_t;

   localparam logic [2:0] LIM = 3'(STARVE_LIM);

   state_t      state;
   logic [2:0]  starve_cnt;
   logic [4:0]  hold_rdc;
   logic [31:0] hold_rd;
   logic        p_grant;
   logic        b_grant;
   logic        md_load;
   logic [2:0]  cnt_inc;

   assign p_grant   = p_we & ~pipe_stall;
   assign b_grant   = buf_busy & ~p_grant;
   assign md_ready  = WBA_rst_n & ~buf_busy;
   assign md_load   = md_valid & md_ready;
   assign buf_rdc   = buf_busy ? hold_rdc : 5'd0;
   assign cnt_inc   = (starve_cnt == 3'd7) ? starve_cnt : starve_cnt + 3'd1;
   assign fsm_state = state;

   always_ff @(posedge WBA_clk) begin
      if (!WBA_rst_n) begin
         state      <= IDLE;
         starve_cnt <= 3'd0;
         hold_rdc   <= 5'd0;
         hold_rd    <= 32'd0;
         buf_busy   <= 1'b0;
         pipe_stall <= 1'b0;
         err_drop   <= 1'b0;
         rf_w       <= 1'b0;
         rf_rdc     <= 5'd0;
         rf_rd      <= 32'd0;
      end else begin
         if (p_we && pipe_stall)
            err_drop <= 1'b1;

         // Index 0 is consumed like any other grant but never written.
         if (p_grant) begin
            rf_w   <= |p_rdc;
            rf_rdc <= p_rdc;
            rf_rd  <= p_rd;
         end else if (b_grant) begin
            rf_w   <= |hold_rdc;
            rf_rdc <= hold_rdc;
            rf_rd  <= hold_rd;
         end else begin
            rf_w   <= 1'b0;
         end

         if (md_load) begin
            hold_rdc <= md_rdc;
            hold_rd  <= md_rd;
            buf_busy <= 1'b1;
         end else if (b_grant) begin
            buf_busy <= 1'b0;
         end

         pipe_stall <= 1'b0;
         case (state)
            IDLE: begin
               starve_cnt <= 3'd0;
               if (md_load)
                  state <= WAIT;
            end
            WAIT: begin
               if (b_grant) begin
                  starve_cnt <= 3'd0;
                  state      <= IDLE;
               end else if (p_grant) begin
                  starve_cnt <= cnt_inc;
                  if (cnt_inc == LIM) begin
                     state      <= FORCE;
                     pipe_stall <= 1'b1;
                  end
               end
            end
            FORCE: begin
               // Pipeline is stalled, so the buffer is granted this cycle.
               starve_cnt <= 3'd0;
               state      <= IDLE;
            end
            default: begin
               starve_cnt <= 3'd0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against
// a cycle-level reference model of the writeback rules.
module tb_rf_wb_arbiter;

   localparam int STARVE_LIM = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        p_we = 1'b0;
   logic [4:0]  p_rdc = '0;
   logic [31:0] p_rd = '0;
   logic        md_valid = 1'b0;
   logic [4:0]  md_rdc = '0;
   logic [31:0] md_rd = '0;
   logic        md_ready, pipe_stall, rf_w, buf_busy, err_drop;
   logic [4:0]  rf_rdc, buf_rdc;
   logic [31:0] rf_rd;
   logic [1:0]  fsm_state;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          m_busy, m_stall, m_err, m_rf_w;
   logic [4:0]  m_rdc, m_rf_rdc;
   logic [31:0] m_data, m_rf_rd;
   int          m_losses;

   rf_wb_arbiter #(.STARVE_LIM(STARVE_LIM)) dut (
      .WBA_clk(clk), .WBA_rst_n(rst_n),
      .p_we(p_we), .p_rdc(p_rdc), .p_rd(p_rd),
      .md_valid(md_valid), .md_rdc(md_rdc), .md_rd(md_rd),
      .md_ready(md_ready), .pipe_stall(pipe_stall),
      .rf_w(rf_w), .rf_rdc(rf_rdc), .rf_rd(rf_rd),
      .buf_busy(buf_busy), .buf_rdc(buf_rdc), .err_drop(err_drop),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // Reference model: applies one cycle of the writeback rules to the inputs
   // present at the rising edge.
   task automatic model_step();
      bit pg, bg, load;
      if (!rst_n) begin
         m_busy = 0; m_stall = 0; m_err = 0; m_rf_w = 0;
         m_rdc = '0; m_rf_rdc = '0; m_data = '0; m_rf_rd = '0; m_losses = 0;
      end else begin
         pg   = p_we && !m_stall;
         bg   = !pg && m_busy;
         load = md_valid && !m_busy;
         if (p_we && m_stall) m_err = 1;
         if (pg) begin
            m_rf_w = (p_rdc != 0); m_rf_rdc = p_rdc; m_rf_rd = p_rd;
         end else if (bg) begin
            m_rf_w = (m_rdc != 0); m_rf_rdc = m_rdc; m_rf_rd = m_data;
         end else begin
            m_rf_w = 0;
         end
         m_stall = 0;
         if (pg && m_busy) begin
            m_losses++;
            if (m_losses == STARVE_LIM) m_stall = 1;
         end else begin
            m_losses = 0;
         end
         if (load) begin
            m_busy = 1; m_rdc = md_rdc; m_data = md_rd;
         end else if (bg) begin
            m_busy = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      p_we = 0; p_rdc = '0; p_rd = '0;
      md_valid = 0; md_rdc = '0; md_rd = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      tick();
      tick();
      checks++; if (rf_w !== 1'b0) begin errors++; $display("FAIL reset_rf_w: got %b want 0", rf_w); end
      checks++; if (rf_rdc !== 5'd0) begin errors++; $display("FAIL reset_rf_rdc: got %0d want 0", rf_rdc); end
      checks++; if (rf_rd !== 32'd0) begin errors++; $display("FAIL reset_rf_rd: got %h want 0", rf_rd); end
      checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", pipe_stall); end
      checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_drop); end
      checks++; if (buf_busy !== 1'b0 || buf_rdc !== 5'd0) begin errors++; $display("FAIL reset_buf: got busy=%b rdc=%0d want 0/0", buf_busy, buf_rdc); end
      checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL reset_md_ready_low: got %b want 0", md_ready); end
      rst_n = 1;
      #1;
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready_high: got %b want 1", md_ready); end
   endtask

   task automatic test_pipe_write();
      do_reset();
      p_we = 1; p_rdc = 5'd5; p_rd = 32'hDEADBEEF;
      tick();
      p_we = 0;
      checks++; if (rf_w !== 1'b1 || rf_rdc !== 5'd5 || rf_rd !== 32'hDEADBEEF) begin
         errors++; $display("FAIL pipe_write: got w=%b rdc=%0d rd=%h want 1/5/deadbeef", rf_w, rf_rdc, rf_rd); end
      tick();
      checks++; if (rf_w !== 1'b0 || rf_rdc !== 5'd5) begin
         errors++; $display("FAIL pipe_write_after: got w=%b rdc=%0d want 0/5", rf_w, rf_rdc); end
   endtask

   task automatic test_md_write();
      do_reset();
      md_valid = 1; md_rdc = 5'd9; md_rd = 32'h12345678;
      tick();
      idle_inputs();
      #1;
      checks++; if (md_ready !== 1'b0 || buf_busy !== 1'b1 || buf_rdc !== 5'd9 || rf_w !== 1'b0) begin
         errors++; $display("FAIL md_buffered: got ready=%b busy=%b rdc=%0d w=%b want 0/1/9/0", md_ready, buf_busy, buf_rdc, rf_w); end
      tick();
      checks++; if (rf_w !== 1'b1 || rf_rdc !== 5'd9 || rf_rd !== 32'h12345678) begin
         errors++; $display("FAIL md_write: got w=%b rdc=%0d rd=%h want 1/9/12345678", rf_w, rf_rdc, rf_rd); end
      checks++; if (md_ready !== 1'b1 || buf_busy !== 1'b0 || buf_rdc !== 5'd0) begin
         errors++; $display("FAIL md_release: got ready=%b busy=%b rdc=%0d want 1/0/0", md_ready, buf_busy, buf_rdc); end
   endtask

   task automatic test_starvation();
      do_reset();
      md_valid = 1; md_rdc = 5'd7; md_rd = 32'hA5A5_0007;
      tick();
      md_valid = 0;
      for (int i = 0; i < STARVE_LIM; i++) begin
         p_we = 1; p_rdc = 5'(10 + i); p_rd = 32'(i);
         tick();
         checks++; if (rf_w !== 1'b1 || rf_rdc !== 5'(10 + i) || rf_rd !== 32'(i)) begin
            errors++; $display("FAIL starve_pipe_%0d: got w=%b rdc=%0d want 1/%0d", i, rf_w, rf_rdc, 10 + i); end
         checks++; if (pipe_stall !== (i == STARVE_LIM - 1)) begin
            errors++; $display("FAIL starve_stall_%0d: got %b want %b", i, pipe_stall, i == STARVE_LIM - 1); end
      end
      p_we = 0;
      tick();
      checks++; if (rf_w !== 1'b1 || rf_rdc !== 5'd7 || rf_rd !== 32'hA5A5_0007) begin
         errors++; $display("FAIL starve_buf_write: got w=%b rdc=%0d rd=%h want 1/7/a5a50007", rf_w, rf_rdc, rf_rd); end
      checks++; if (pipe_stall !== 1'b0 || buf_busy !== 1'b0 || err_drop !== 1'b0) begin
         errors++; $display("FAIL starve_after: got stall=%b busy=%b err=%b want 0/0/0", pipe_stall, buf_busy, err_drop); end
   endtask

   task automatic test_zero_index();
      do_reset();
      p_we = 1; p_rdc = 5'd0; p_rd = 32'h1111_2222;
      md_valid = 1; md_rdc = 5'd0; md_rd = 32'h3333_4444;
      tick();
      idle_inputs();
      checks++; if (rf_w !== 1'b0 || buf_busy !== 1'b1) begin
         errors++; $display("FAIL zero_pipe: got w=%b busy=%b want 0/1", rf_w, buf_busy); end
      tick();
      checks++; if (rf_w !== 1'b0 || buf_busy !== 1'b0 || rf_rdc !== 5'd0) begin
         errors++; $display("FAIL zero_buf: got w=%b busy=%b rdc=%0d want 0/0/0", rf_w, buf_busy, rf_rdc); end
   endtask

   task automatic test_err_drop();
      do_reset();
      md_valid = 1; md_rdc = 5'd4; md_rd = 32'h0000_0444;
      tick();
      md_valid = 0;
      for (int i = 0; i < STARVE_LIM; i++) begin
         p_we = 1; p_rdc = 5'd20; p_rd = 32'(i);
         tick();
      end
      checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL err_stall: got %b want 1", pipe_stall); end
      p_we = 1; p_rdc = 5'd12; p_rd = 32'hBAD0_BAD0;
      tick();
      p_we = 0;
      checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_drop); end
      checks++; if (rf_w !== 1'b1 || rf_rdc !== 5'd4 || rf_rd !== 32'h0000_0444) begin
         errors++; $display("FAIL err_no_write: got w=%b rdc=%0d rd=%h want 1/4/00000444", rf_w, rf_rdc, rf_rd); end
      for (int i = 0; i < 3; i++) tick();
      checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_drop); end
      rst_n = 0;
      tick();
      rst_n = 1;
      checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err_drop); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      md_valid = 1; md_rdc = 5'd3; md_rd = 32'h0000_0333;
      tick();
      md_valid = 0;
      checks++; if (buf_busy !== 1'b1 || buf_rdc !== 5'd3) begin
         errors++; $display("FAIL rmid_loaded: got busy=%b rdc=%0d want 1/3", buf_busy, buf_rdc); end
      rst_n = 0;
      tick();
      checks++; if (buf_busy !== 1'b0 || rf_w !== 1'b0) begin
         errors++; $display("FAIL rmid_reset: got busy=%b w=%b want 0/0", buf_busy, rf_w); end
      rst_n = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if (rf_w !== 1'b0) begin
            errors++; $display("FAIL rmid_no_write_%0d: got w=%b rdc=%0d want w=0", i, rf_w, rf_rdc); end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst_n    = ($urandom_range(0, 79) != 0);
         p_we     = m_stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
         p_rdc    = 5'($urandom_range(0, 31));
         p_rd     = $urandom;
         md_valid = ($urandom_range(0, 2) != 0);
         md_rdc   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         md_rd    = $urandom;
         #1;
         checks++; if (md_ready !== (rst_n && !m_busy)) begin
            errors++; $display("FAIL rnd_md_ready c=%0d: got %b want %b", c, md_ready, rst_n && !m_busy); end
         tick();
         checks++; if (rf_w !== m_rf_w || rf_rdc !== m_rf_rdc || rf_rd !== m_rf_rd) begin
            errors++; $display("FAIL rnd_rf c=%0d: got w=%b rdc=%0d rd=%h want %b/%0d/%h", c, rf_w, rf_rdc, rf_rd, m_rf_w, m_rf_rdc, m_rf_rd); end
         checks++; if (pipe_stall !== m_stall || err_drop !== m_err) begin
            errors++; $display("FAIL rnd_flags c=%0d: got stall=%b err=%b want %b/%b", c, pipe_stall, err_drop, m_stall, m_err); end
         checks++; if (buf_busy !== m_busy || buf_rdc !== (m_busy ? m_rdc : 5'd0)) begin
            errors++; $display("FAIL rnd_buf c=%0d: got busy=%b rdc=%0d want %b/%0d", c, buf_busy, buf_rdc, m_busy, m_busy ? m_rdc : 5'd0); end
      end
      idle_inputs();
      rst_n = 1;
   endtask

   initial begin
      test_reset();
      test_pipe_write();
      test_md_write();
      test_starvation();
      test_zero_index();
      test_err_drop();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIM, default 4, max consecutive cycles a buffered MD result may lose arbitration before a forced pipeline stall; legal range 1..7.
REQ-002 WBA_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 WBA_rst_n  input  1  reset; synchronous, active-low.
REQ-004 p_we  input  1  pipeline writeback request, valid for the current cycle only.
REQ-005 p_rdc  input  5  pipeline destination register index.
REQ-006 p_rd  input  32  pipeline writeback data.
REQ-007 md_valid  input  1  mul/div unit result valid.
REQ-008 md_rdc  input  5  mul/div destination register index.
REQ-009 md_rd  input  32  mul/div result data.
REQ-010 md_ready  output  1  arbiter can accept an MD result this cycle.
REQ-011 pipe_stall  output  1  registered; pipeline SHALL present p_we=0 in any cycle where it is 1.
REQ-012 rf_w  output  1  registered register-file write enable.
REQ-013 rf_rdc  output  5  registered register-file write index.
REQ-014 rf_rd  output  32  registered register-file write data.
REQ-015 buf_busy  output  1  MD holding buffer occupied, for hazard detection.
REQ-016 buf_rdc  output  5  destination index held in the buffer; 0 when buffer empty.
REQ-017 err_drop  output  1  sticky flag: pipeline write arrived during pipe_stall.

Function
REQ-018 Holding buffer is one entry; md_ready SHALL equal ~buf_busy while WBA_rst_n=1, and 0 while WBA_rst_n=0.
REQ-019 MD handshake: buffer loads md_rdc/md_rd at the edge where md_valid=1 and md_ready=1; no load otherwise.
REQ-020 Arbitration per cycle, fixed priority: (a) p_we=1 and pipe_stall=0 -> grant pipeline; (b) else buf_busy=1 -> grant buffer; (c) else no grant.
REQ-021 Latency: the grant made in cycle t appears on rf_w/rf_rdc/rf_rd after the edge ending cycle t (one cycle).
REQ-022 On any grant, rf_rdc/rf_rd take the granted index/data; rf_w = 1 only if granted index != 0.
REQ-023 A grant with index 0 SHALL consume the request (buffer clears) with rf_w=0.
REQ-024 With no grant, rf_w=0 and rf_rdc/rf_rd hold previous values.
REQ-025 Buffer grant clears buf_busy at the same edge; a new MD result is accepted no earlier than the next cycle (max MD throughput one per two cycles).
REQ-026 FSM states: IDLE (buffer empty), WAIT (buffer full, losing/awaiting grant), FORCE (pipe_stall=1).
REQ-027 IDLE->WAIT on buffer load; WAIT->IDLE on buffer grant; WAIT->FORCE when starvation counter reaches STARVE_LIM; FORCE->IDLE unconditionally after one cycle (buffer granted during FORCE).
REQ-028 Starvation counter (3 bits) increments each cycle in WAIT where the pipeline wins; clears to 0 on buffer grant or in IDLE; never wraps.
REQ-029 pipe_stall SHALL be 1 exactly in FORCE state, for exactly one cycle per starvation event.
REQ-030 p_we=1 while pipe_stall=1: request ignored (no grant, no write) and err_drop set to 1 until reset.
REQ-031 Simultaneous p_we=1 and buffer grant eligible outside FORCE: pipeline wins, counter increments.

Reset
REQ-032 While WBA_rst_n=0 at a rising edge: rf_w=0, rf_rdc=0, rf_rd=0, pipe_stall=0, err_drop=0, buf_busy=0, buf_rdc=0, counter=0, state=IDLE.
REQ-033 Reset asserted mid-operation discards any buffered MD result; no register-file write for it occurs after reset.

Verification
REQ-034 p_we=1, p_rdc=5, p_rd=0xDEADBEEF in cycle t -> rf_w=1, rf_rdc=5, rf_rd=0xDEADBEEF in cycle t+1, then rf_w=0.
REQ-035 md_valid=1, md_rdc=9, md_rd=0x12345678, p_we=0 -> md_ready drops next cycle, buf_busy=1/buf_rdc=9 for one cycle, rf_w=1/rf_rdc=9 the cycle after, md_ready returns to 1.
REQ-036 Buffer full, p_we=1 every cycle, STARVE_LIM=4 -> 4 pipeline writes, then pipe_stall=1 for one cycle, buffer written next cycle, pipe_stall=0.
REQ-037 p_we=1 with p_rdc=0, md result with md_rdc=0 -> both consumed, rf_w stays 0, buf_busy clears.
REQ-038 p_we=1 during pipe_stall=1 -> no write of that data, err_drop=1 and stays 1 until WBA_rst_n=0.
REQ-039 Buffer full with md_rdc=3, WBA_rst_n=0 for one cycle -> buf_busy=0, rf_w=0, register 3 never written afterward.
